// File: rtl/lockstep_pkg.sv
// Shared types and constants for the lockstep request merger.
package lockstep_pkg;

  localparam int unsigned ADDR_WIDTH = 32;
  localparam int unsigned DATA_WIDTH = 32;
  localparam int unsigned BE_WIDTH   = DATA_WIDTH / 8;

  localparam logic [DATA_WIDTH-1:0] ERR_RDATA = '0;

  typedef enum logic [2:0] {
    StIdle,
    StCollect,
    StIssue,
    StWaitRsp,
    StResp,
    StErrRsp
  } state_e;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] add;
    logic                  wen;
    logic [DATA_WIDTH-1:0] wdata;
    logic [BE_WIDTH-1:0]   be;
  } req_fields_t;

endpackage

// File: rtl/lockstep_req_merger_if.sv
// Downstream peripheral-interconnect port: one request channel plus its response.
interface lockstep_req_merger_if #(
  parameter int unsigned ID_WIDTH = 5
);
  import lockstep_pkg::*;

  logic                  req;
  logic [ADDR_WIDTH-1:0] add;
  logic                  wen;
  logic [DATA_WIDTH-1:0] wdata;
  logic [BE_WIDTH-1:0]   be;
  logic [ID_WIDTH-1:0]   id;
  logic                  gnt;
  logic                  r_valid;
  logic [DATA_WIDTH-1:0] r_rdata;
  logic                  r_opc;
  logic [ID_WIDTH-1:0]   r_id;

  modport master (
    output req, add, wen, wdata, be, id,
    input  gnt, r_valid, r_rdata, r_opc, r_id
  );

  modport slave (
    input  req, add, wen, wdata, be, id,
    output gnt, r_valid, r_rdata, r_opc, r_id
  );

endinterface

// File: rtl/lockstep_cmp.sv
// Combinational N-way comparison of every core's request fields against core 0.
module lockstep_cmp
  import lockstep_pkg::*;
#(
  parameter int unsigned NB_CORES = 8
) (
  input  req_fields_t         fields_i [NB_CORES],
  output logic [NB_CORES-1:0] diff_o
);

  always_comb begin
    diff_o = '0;
    for (int unsigned i = 1; i < NB_CORES; i++) begin
      diff_o[i] = (fields_i[i] != fields_i[0]);
    end
  end

endmodule

// File: rtl/lockstep_req_merger.sv
// Merges redundant lockstep core requests into one downstream transaction and
// fans the single response back to every participating core.
module lockstep_req_merger
  import lockstep_pkg::*;
#(
  parameter int unsigned NB_CORES = 8,
  parameter int unsigned ID_WIDTH = 5,
  parameter int unsigned SKEW_MAX = 4
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  logic                           lockstep_en_i,
  input  logic [NB_CORES-1:0]            core_req_i,
  input  logic [NB_CORES*ADDR_WIDTH-1:0] core_add_i,
  input  logic [NB_CORES-1:0]            core_wen_i,
  input  logic [NB_CORES*DATA_WIDTH-1:0] core_wdata_i,
  input  logic [NB_CORES*BE_WIDTH-1:0]   core_be_i,
  input  logic [NB_CORES*ID_WIDTH-1:0]   core_id_i,
  output logic [NB_CORES-1:0]            core_gnt_o,
  output logic [NB_CORES-1:0]            core_r_valid_o,
  output logic [DATA_WIDTH-1:0]          core_r_rdata_o,
  output logic                           core_r_opc_o,
  output logic [NB_CORES*ID_WIDTH-1:0]   core_r_id_o,
  lockstep_req_merger_if.master          per_bus,
  output logic                           mismatch_o,
  output logic                           skew_err_o,
  output logic [NB_CORES-1:0]            err_mask_o
);

  localparam int unsigned CntW = $clog2(SKEW_MAX + 1);

  state_e                       state_q, state_d;
  logic [NB_CORES-1:0]          act_q, act_d, vmask_q, vmask_d, err_mask_q, err_mask_d;
  logic [CntW-1:0]              cnt_q, cnt_d;
  req_fields_t                  fields_q, fields_d;
  logic [NB_CORES*ID_WIDTH-1:0] ids_q, ids_d;
  logic [DATA_WIDTH-1:0]        rdata_q, rdata_d;
  logic                         opc_q, opc_d, mismatch_q, mismatch_d, skew_q, skew_d;

  req_fields_t         core_fields [NB_CORES];
  logic [NB_CORES-1:0] diff, en_mask;
  logic                all_in;
  logic                unused_rid;

  assign unused_rid = ^per_bus.r_id;
  assign en_mask    = lockstep_en_i ? {NB_CORES{1'b1}} : NB_CORES'(1);
  assign all_in     = (core_req_i & act_q) == act_q;

  always_comb begin
    for (int unsigned i = 0; i < NB_CORES; i++) begin
      core_fields[i].add   = core_add_i[i*ADDR_WIDTH +: ADDR_WIDTH];
      core_fields[i].wen   = core_wen_i[i];
      core_fields[i].wdata = core_wdata_i[i*DATA_WIDTH +: DATA_WIDTH];
      core_fields[i].be    = core_be_i[i*BE_WIDTH +: BE_WIDTH];
    end
  end

  lockstep_cmp #(
    .NB_CORES(NB_CORES)
  ) u_cmp (
    .fields_i(core_fields),
    .diff_o  (diff)
  );

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q    <= StIdle;
      act_q      <= '0;
      vmask_q    <= '0;
      err_mask_q <= '0;
      cnt_q      <= '0;
      fields_q   <= '0;
      ids_q      <= '0;
      rdata_q    <= '0;
      opc_q      <= 1'b0;
      mismatch_q <= 1'b0;
      skew_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      act_q      <= act_d;
      vmask_q    <= vmask_d;
      err_mask_q <= err_mask_d;
      cnt_q      <= cnt_d;
      fields_q   <= fields_d;
      ids_q      <= ids_d;
      rdata_q    <= rdata_d;
      opc_q      <= opc_d;
      mismatch_q <= mismatch_d;
      skew_q     <= skew_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    act_d      = act_q;
    vmask_d    = vmask_q;
    err_mask_d = err_mask_q;
    cnt_d      = cnt_q;
    fields_d   = fields_q;
    ids_d      = ids_q;
    rdata_d    = rdata_q;
    opc_d      = opc_q;
    mismatch_d = 1'b0;
    skew_d     = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (|(core_req_i & en_mask)) begin
          act_d      = en_mask;
          cnt_d      = '0;
          err_mask_d = '0;
          state_d    = StCollect;
        end
      end
      StCollect: begin
        cnt_d = cnt_q + CntW'(1);
        // Arrival wins over skew: a core showing up on the last allowed cycle is accepted.
        if (all_in) begin
          ids_d = core_id_i;
          if (|(diff & act_q)) begin
            mismatch_d = 1'b1;
            err_mask_d = diff & act_q;
            state_d    = StErrRsp;
          end else begin
            fields_d = core_fields[0];
            state_d  = StIssue;
          end
        end else if (cnt_d == CntW'(SKEW_MAX)) begin
          skew_d     = 1'b1;
          err_mask_d = act_q & ~core_req_i;
          ids_d      = core_id_i;
          state_d    = StErrRsp;
        end
      end
      StIssue: begin
        if (per_bus.gnt) begin
          vmask_d = act_q;
          state_d = StWaitRsp;
        end
      end
      StWaitRsp: begin
        if (per_bus.r_valid) begin
          rdata_d = per_bus.r_rdata;
          opc_d   = per_bus.r_opc;
          state_d = StResp;
        end
      end
      StResp: state_d = StIdle;
      StErrRsp: begin
        vmask_d = act_q & core_req_i;
        rdata_d = ERR_RDATA;
        opc_d   = 1'b1;
        state_d = StResp;
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    core_gnt_o     = '0;
    core_r_valid_o = '0;
    per_bus.req    = 1'b0;
    unique case (state_q)
      StIssue: begin
        per_bus.req = 1'b1;
        if (per_bus.gnt) core_gnt_o = act_q;
      end
      StErrRsp: core_gnt_o     = act_q & core_req_i;
      StResp:   core_r_valid_o = vmask_q;
      default: ;
    endcase
  end

  assign per_bus.add    = fields_q.add;
  assign per_bus.wen    = fields_q.wen;
  assign per_bus.wdata  = fields_q.wdata;
  assign per_bus.be     = fields_q.be;
  assign per_bus.id     = ids_q[ID_WIDTH-1:0];
  assign core_r_rdata_o = rdata_q;
  assign core_r_opc_o   = opc_q;
  assign core_r_id_o    = ids_q;
  assign mismatch_o     = mismatch_q;
  assign skew_err_o     = skew_q;
  assign err_mask_o     = err_mask_q;

endmodule

// File: tb/tb_lockstep_req_merger.sv
// Randomized transaction-level bench for lockstep_req_merger with an outcome-predicting model.
module tb_lockstep_req_merger;

  localparam int NB   = 8;
  localparam int IDW  = 5;
  localparam int SKEW = 4;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              en = 1'b1;
  logic [NB-1:0]     core_req = '0;
  logic [NB*32-1:0]  core_add, core_wdata;
  logic [NB-1:0]     core_wen;
  logic [NB*4-1:0]   core_be;
  logic [NB*IDW-1:0] core_id;
  logic [NB-1:0]     core_gnt, core_rv, err_mask;
  logic [31:0]       core_rdata;
  logic              core_opc, mismatch, skew_err;
  logic [NB*IDW-1:0] core_rid;

  logic [31:0]    add_v   [NB];
  logic [31:0]    wdata_v [NB];
  logic [3:0]     be_v    [NB];
  logic [IDW-1:0] id_v    [NB];
  logic [NB-1:0]  wen_v;
  int             arr     [NB];
  int             gnt_dly, rsp_dly;
  logic [31:0]    rdata_v;
  logic           opc_v;

  int n_vec = 0;
  int n_err = 0;

  lockstep_req_merger_if #(.ID_WIDTH(IDW)) bus ();

  for (genvar g = 0; g < NB; g++) begin : g_pack
    assign core_add[g*32 +: 32]    = add_v[g];
    assign core_wdata[g*32 +: 32]  = wdata_v[g];
    assign core_be[g*4 +: 4]       = be_v[g];
    assign core_id[g*IDW +: IDW]   = id_v[g];
    assign core_wen[g]             = wen_v[g];
  end

  lockstep_req_merger #(
    .NB_CORES(NB),
    .ID_WIDTH(IDW),
    .SKEW_MAX(SKEW)
  ) dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .lockstep_en_i (en),
    .core_req_i    (core_req),
    .core_add_i    (core_add),
    .core_wen_i    (core_wen),
    .core_wdata_i  (core_wdata),
    .core_be_i     (core_be),
    .core_id_i     (core_id),
    .core_gnt_o    (core_gnt),
    .core_r_valid_o(core_rv),
    .core_r_rdata_o(core_rdata),
    .core_r_opc_o  (core_opc),
    .core_r_id_o   (core_rid),
    .per_bus       (bus),
    .mismatch_o    (mismatch),
    .skew_err_o    (skew_err),
    .err_mask_o    (err_mask)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h required %0h", tag, got, exp);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_req"},    64'(bus.req), 64'(0));
    check({tag, "_add"},    64'(bus.add), 64'(0));
    check({tag, "_gnt"},    64'(core_gnt), 64'(0));
    check({tag, "_rvalid"}, 64'(core_rv), 64'(0));
    check({tag, "_rdata"},  64'(core_rdata), 64'(0));
    check({tag, "_rid"},    64'(core_rid), 64'(0));
    check({tag, "_opc"},    64'(core_opc), 64'(0));
    check({tag, "_flags"},  64'({mismatch, skew_err, err_mask}), 64'(0));
  endtask

  task automatic set_uniform(input logic e, input logic [31:0] a, input logic w,
                             input logic [31:0] wd, input logic [3:0] b);
    en = e;
    for (int i = 0; i < NB; i++) begin
      add_v[i] = a; wen_v[i] = w; wdata_v[i] = wd; be_v[i] = b;
      id_v[i] = IDW'($urandom); arr[i] = 0;
    end
    gnt_dly = 0; rsp_dly = 1; rdata_v = $urandom; opc_v = 1'b0;
  endtask

  task automatic gen_random();
    int mode, c, mn;
    logic [31:0] a, wd;
    logic w;
    logic [3:0] b;
    en = ($urandom_range(0, 3) != 0);
    a = $urandom; wd = $urandom; w = 1'($urandom_range(0, 1)); b = 4'($urandom_range(0, 15));
    for (int i = 0; i < NB; i++) begin
      add_v[i] = a; wen_v[i] = w; wdata_v[i] = wd; be_v[i] = b;
      id_v[i] = IDW'($urandom); arr[i] = $urandom_range(0, SKEW);
    end
    mode = $urandom_range(0, 3);
    if (mode == 2) begin
      c = $urandom_range(1, NB - 1);
      case ($urandom_range(0, 3))
        0:       add_v[c]   = add_v[c] ^ (32'd1 << $urandom_range(0, 31));
        1:       wdata_v[c] = wdata_v[c] ^ (32'd1 << $urandom_range(0, 31));
        2:       be_v[c]    = be_v[c] ^ (4'd1 << $urandom_range(0, 3));
        default: wen_v[c]   = ~wen_v[c];
      endcase
    end
    if (mode == 3) arr[$urandom_range(0, NB - 1)] = -1;
    if (!en) begin
      arr[0] = 0;
      for (int i = 1; i < NB; i++) begin
        arr[i] = ($urandom_range(0, 1) != 0) ? int'($urandom_range(0, 8)) : -1;
        add_v[i] = $urandom;
      end
    end else begin
      mn = 99;
      for (int i = 0; i < NB; i++) if (arr[i] >= 0 && arr[i] < mn) mn = arr[i];
      for (int i = 0; i < NB; i++) if (arr[i] >= 0) arr[i] = arr[i] - mn;
    end
    gnt_dly = $urandom_range(0, 3); rsp_dly = $urandom_range(1, 3);
    rdata_v = $urandom; opc_v = ($urandom_range(0, 7) == 0);
  endtask

  // Predicts the outcome from arrival times and field equality, then plays the downstream slave.
  task automatic run_txn();
    logic [NB-1:0] act, late, diffm, exp_gnt, exp_err, granted, gnt_obs, v_mask;
    logic [NB*IDW-1:0] idm, exp_ids, v_ids;
    logic [31:0] exp_rdata, v_rdata;
    logic exp_opc, v_opc;
    int kind, last, d, req_cnt, first_req, dn_gnt, gnt_cyc, gnt_cycles, bad_fields;
    int mis_cnt, skew_cnt, pulse_cyc, v_cnt, v_cyc;
    act = en ? {NB{1'b1}} : NB'(1);
    late = '0; last = 0;
    for (int i = 0; i < NB; i++) begin
      if (act[i]) begin
        if (arr[i] < 0 || arr[i] > SKEW) late[i] = 1'b1;
        else if (arr[i] > last) last = arr[i];
      end
    end
    diffm = '0;
    for (int i = 1; i < NB; i++) begin
      if (act[i] && (add_v[i] !== add_v[0] || wen_v[i] !== wen_v[0] ||
                     wdata_v[i] !== wdata_v[0] || be_v[i] !== be_v[0])) diffm[i] = 1'b1;
    end
    d = ((last < 1) ? 1 : last) + 1;
    if (late != '0) begin
      kind = 2; exp_err = late; exp_gnt = act & ~late; d = SKEW + 1;
    end else if (diffm != '0) begin
      kind = 1; exp_err = diffm; exp_gnt = act;
    end else begin
      kind = 0; exp_err = '0; exp_gnt = act;
    end
    exp_rdata = (kind == 0) ? rdata_v : 32'd0;
    exp_opc   = (kind == 0) ? opc_v : 1'b1;
    idm = '0; exp_ids = '0;
    for (int i = 0; i < NB; i++) begin
      if (exp_gnt[i]) begin
        idm[i*IDW +: IDW] = '1;
        exp_ids[i*IDW +: IDW] = id_v[i];
      end
    end

    granted = '0; gnt_obs = '0; v_mask = '0; v_ids = '0; v_rdata = '0; v_opc = 1'b0;
    req_cnt = 0; first_req = -1; dn_gnt = -1; gnt_cyc = -1; gnt_cycles = 0; bad_fields = 0;
    mis_cnt = 0; skew_cnt = 0; pulse_cyc = -1; v_cnt = 0; v_cyc = -1;
    for (int k = 0; k < 60; k++) begin
      @(posedge clk); #1;
      for (int i = 0; i < NB; i++) core_req[i] = (arr[i] >= 0 && k >= arr[i] && !granted[i]);
      bus.gnt = 1'b0; bus.r_valid = 1'b0;
      #1;
      if (bus.req) begin
        if (first_req < 0) first_req = k;
        req_cnt++;
        if (bus.add !== add_v[0] || bus.wen !== wen_v[0] || bus.wdata !== wdata_v[0] ||
            bus.be !== be_v[0] || bus.id !== id_v[0]) bad_fields++;
        if (k - first_req == gnt_dly) begin bus.gnt = 1'b1; dn_gnt = k; end
      end
      if (dn_gnt >= 0 && k == dn_gnt + rsp_dly) begin
        bus.r_valid = 1'b1; bus.r_rdata = rdata_v; bus.r_opc = opc_v; bus.r_id = IDW'($urandom);
      end
      #1;
      if (core_gnt != '0) begin
        gnt_cycles++; gnt_obs |= core_gnt;
        if (gnt_cyc < 0) gnt_cyc = k;
      end
      granted |= core_gnt;
      if (mismatch) begin mis_cnt++; if (pulse_cyc < 0) pulse_cyc = k; end
      if (skew_err) begin skew_cnt++; if (pulse_cyc < 0) pulse_cyc = k; end
      if (core_rv != '0) begin
        v_cnt++;
        if (v_cyc < 0) begin
          v_cyc = k; v_mask = core_rv; v_rdata = core_rdata; v_opc = core_opc;
          v_ids = core_rid & idm;
        end
      end
      if (v_cyc >= 0 && k >= v_cyc + 2) break;
    end
    @(posedge clk); #1;
    core_req = '0; bus.gnt = 1'b0; bus.r_valid = 1'b0;

    check("req_cycles",  64'(req_cnt),    64'((kind == 0) ? gnt_dly + 1 : 0));
    check("req_first",   64'(first_req),  64'((kind == 0) ? d : -1));
    check("req_fields",  64'(bad_fields), 64'(0));
    check("gnt_mask",    64'(gnt_obs),    64'(exp_gnt));
    check("gnt_cycles",  64'(gnt_cycles), 64'(1));
    check("gnt_cycle",   64'(gnt_cyc),    64'((kind == 0) ? d + gnt_dly : d));
    check("mismatch",    64'(mis_cnt),    64'((kind == 1) ? 1 : 0));
    check("skew_err",    64'(skew_cnt),   64'((kind == 2) ? 1 : 0));
    check("pulse_cycle", 64'(pulse_cyc),  64'((kind != 0) ? d : -1));
    check("err_mask",    64'(err_mask),   64'(exp_err));
    check("rvalid_mask", 64'(v_mask),     64'(exp_gnt));
    check("rvalid_cnt",  64'(v_cnt),      64'(1));
    check("rvalid_cyc",  64'(v_cyc),
          64'((kind == 0) ? d + gnt_dly + rsp_dly + 1 : d + 1));
    check("rdata",       64'(v_rdata),    64'(exp_rdata));
    check("opc",         64'(v_opc),      64'(exp_opc));
    check("rid",         64'(v_ids),      64'(exp_ids));
    repeat (2) @(posedge clk);
  endtask

  task automatic run_reset_mid();
    logic [NB-1:0] g;
    int v_cnt;
    set_uniform(1'b1, 32'h2000_0100, 1'b1, 32'd0, 4'hF);
    id_v[0] = 5'h11;
    g = '0;
    for (int k = 0; k < 20 && g != {NB{1'b1}}; k++) begin
      @(posedge clk); #1;
      core_req = ~g; bus.gnt = 1'b0;
      #1;
      bus.gnt = bus.req;
      #1;
      g |= core_gnt;
    end
    check("rst_pre_gnt", 64'(g), 64'({NB{1'b1}}));
    @(posedge clk); #1;
    core_req = '0; bus.gnt = 1'b0; rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    check_idle_outputs("rst_mid");
    v_cnt = 0;
    for (int k = 0; k < 4; k++) begin
      bus.r_valid = (k == 0); bus.r_rdata = 32'hDEAD_BEEF; bus.r_opc = 1'b0;
      #1;
      if (core_rv != '0) v_cnt++;
      @(posedge clk); #1;
    end
    bus.r_valid = 1'b0;
    check("rst_drop_rsp", 64'(v_cnt), 64'(0));
  endtask

  initial begin
    bus.gnt = 1'b0; bus.r_valid = 1'b0; bus.r_rdata = '0; bus.r_opc = 1'b0; bus.r_id = '0;
    set_uniform(1'b1, 32'd0, 1'b1, 32'd0, 4'd0);
    repeat (3) @(posedge clk);
    #1;
    check_idle_outputs("reset");
    rst_n = 1'b1;
    @(posedge clk);

    set_uniform(1'b1, 32'h1020_0010, 1'b1, 32'd0, 4'hF);
    rdata_v = 32'hCAFE_F00D;
    run_txn();

    set_uniform(1'b1, $urandom, 1'b1, 32'd0, 4'hF);
    arr[5] = 3;
    run_txn();

    set_uniform(1'b1, $urandom, 1'b1, 32'd0, 4'hF);
    arr[4] = SKEW;
    run_txn();

    set_uniform(1'b1, 32'h1000_0040, 1'b0, 32'd0, 4'hF);
    wdata_v[3] = 32'd1;
    run_txn();

    set_uniform(1'b1, $urandom, 1'b1, 32'd0, 4'hF);
    arr[7] = -1;
    run_txn();

    set_uniform(1'b1, $urandom, 1'b0, $urandom, 4'h3);
    gnt_dly = 5; rsp_dly = 2;
    run_txn();

    set_uniform(1'b0, $urandom, 1'b1, 32'd0, 4'hF);
    for (int i = 1; i < NB; i++) begin arr[i] = i % 3; add_v[i] = $urandom; end
    run_txn();

    run_reset_mid();
    set_uniform(1'b1, $urandom, 1'b1, 32'd0, 4'hF);
    run_txn();

    repeat (60) begin
      gen_random();
      run_txn();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
